store_trace_checker: RTL and testbench
======================================

# store_trace_checker

Synthesizable self-checking monitor on the single-cycle core's data-memory write port (MemWrite, ALUResult, WriteData). It holds a programmable table of up to DEPTH expected stores (address, data) and checks committed stores against it in order, in strict or loose mode, with a cycle-timeout watchdog. It reports sticky pass/fail, so on-chip and simulation runs both get a single pass/fail verdict.

## Interface
- ADDR_W, 32, store address width (ALUResult)
- DATA_W, 32, store data width (WriteData)
- DEPTH, 4, max expected-store entries (≥1); IDX_W = $clog2(DEPTH) (min 1)
- TIMEOUT_CYCLES, 4096, watchdog limit in RUN cycles; 0 disables
- STRICT, 1, 1 = every store must match the next entry; 0 = non-matching stores to other addresses are ignored

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- cfg_we  in  1  write table entry cfg_idx (honoured in IDLE only)
- cfg_idx  in  IDX_W  entry index
- cfg_addr  in  ADDR_W  expected address
- cfg_data  in  DATA_W  expected data
- cfg_len  in  IDX_W+1  number of valid entries, sampled on start
- start  in  1  arm checker (honoured in IDLE, PASS, FAIL)
- MemWrite  in  1  store commit strobe from core
- ALUResult  in  ADDR_W  store address
- WriteData  in  DATA_W  store data
- busy  out  1  state == RUN
- pass  out  1  sticky pass
- fail  out  1  sticky fail
- timeout  out  1  fail caused by watchdog
- fail_idx  out  IDX_W  entry pointer at failure
- match_count  out  IDX_W+1  entries matched so far
- store_count  out  16  stores observed in RUN, saturates at 16'hFFFF

## Operation
- States: IDLE, RUN, PASS, FAIL. Reset → IDLE; all outputs 0, table contents undefined, len=0.
- cfg_we in IDLE writes entry[cfg_idx]; cfg_idx ≥ DEPTH ignored; cfg_we in any other state ignored.
- start in IDLE/PASS/FAIL: len←min(cfg_len, DEPTH); ptr, match_count, store_count, timer, fail_idx, timeout, pass, fail cleared. len=0 → PASS; else → RUN. start in RUN ignored.
- RUN, MemWrite=1: store_count+1 (saturating); compare against entry[ptr]:
  - addr and data equal: ptr+1, match_count+1; if ptr == len-1 → PASS.
  - STRICT=1, any mismatch: → FAIL, fail_idx=ptr.
  - STRICT=0, address equal, data differs: → FAIL, fail_idx=ptr.
  - STRICT=0, address differs: ignored, no state change beyond store_count.
- RUN, MemWrite=0: no compare.
- Watchdog: timer counts every RUN cycle from 0; when timer reaches TIMEOUT_CYCLES-1 with no terminal event that cycle → FAIL, timeout=1, fail_idx=ptr.
- Priority in one cycle: final-entry match (PASS) > data mismatch (FAIL) > timeout.
- PASS/FAIL sticky until start or reset; MemWrite ignored there (store_count frozen).
- pass and fail are never both 1.

## Timing
- Inputs sampled at rising clk; all outputs registered, visible the cycle after the sampling edge.
- One store checked per cycle, back-to-back stores supported with no bubble.
- Verdict latency: 1 cycle after the deciding store edge.
- Timeout: fail asserts exactly TIMEOUT_CYCLES cycles after the start edge if undecided.
- rst low at any time (including mid-RUN) forces IDLE and all outputs 0 immediately, without waiting for clk; first start accepted on the first edge after rst deasserts.
- cfg_we and start in the same IDLE cycle: the entry write and the arm both take effect; the entry written that cycle is used.

## Test plan
- STRICT=1, len=2, table {(96,7),(100,25)}; stores (96,7), (100,25) back-to-back → pass=1 one cycle after second, match_count=2, store_count=2.
- STRICT=1, same table; store (104,7) → fail=1, fail_idx=0, timeout=0, store_count=1.
- STRICT=0, len=1, table {(100,25)}; stores (96,3),(96,9),(100,25) → pass=1, store_count=3, match_count=1.
- STRICT=0, same table; store (100,24) → fail=1, fail_idx=0.
- TIMEOUT_CYCLES=16, len=1, no stores → fail=1 and timeout=1 exactly 16 cycles after start; final match on cycle 16 instead → pass=1.
- Mid-RUN rst pulse low → all outputs 0 asynchronously; cfg_we during RUN does not alter table (re-run after start matches original entries).

Source files
------------

// File: rtl/store_trace_checker.sv
// Watches the core's data-memory write port and checks committed stores, in order,
// against a programmable table of expected (address, data) pairs, with a watchdog.
module store_trace_checker #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter bit STRICT         = 1'b1,
    localparam int IDX_W         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic [IDX_W:0]    cfg_len,
    input  logic              start,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] ALUResult,
    input  logic [DATA_W-1:0] WriteData,
    output logic              busy,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [IDX_W-1:0]  fail_idx,
    output logic [IDX_W:0]    match_count,
    output logic [15:0]       store_count
);

    typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} stateT;

    localparam logic [IDX_W:0] DEPTH_LEN = (IDX_W+1)'(DEPTH);
    localparam logic [31:0]    TIMER_LAST = 32'(TIMEOUT_CYCLES - 1);

    stateT             state;
    logic [IDX_W:0]    lenReg;
    logic [IDX_W-1:0]  ptr;
    logic [31:0]       timer;

    logic [ADDR_W-1:0] tabAddr [DEPTH];
    logic [DATA_W-1:0] tabData [DEPTH];

    logic [IDX_W:0]    clampedLen;
    logic              addrEq;
    logic              dataEq;
    logic              storeHit;
    logic              storeBad;
    logic              lastEntry;
    logic              timerExpired;

    // Table contents are deliberately not reset; only len decides which entries matter.
    always_ff @(posedge clk) begin
        if (cfg_we && state == IDLE && int'(cfg_idx) < DEPTH) begin
            tabAddr[cfg_idx] <= cfg_addr;
            tabData[cfg_idx] <= cfg_data;
        end
    end

    always_comb begin
        clampedLen   = (cfg_len > DEPTH_LEN) ? DEPTH_LEN : cfg_len;
        addrEq       = (ALUResult == tabAddr[ptr]);
        dataEq       = (WriteData == tabData[ptr]);
        storeHit     = MemWrite && addrEq && dataEq;
        storeBad     = MemWrite && (STRICT ? !(addrEq && dataEq) : (addrEq && !dataEq));
        lastEntry    = ({1'b0, ptr} + 1'b1) == lenReg;
        timerExpired = (TIMEOUT_CYCLES != 0) && (timer == TIMER_LAST);
    end

    // Verdict priority within one RUN cycle: final match, then bad store, then watchdog.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            lenReg      <= '0;
            ptr         <= '0;
            timer       <= '0;
            busy        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            timeout     <= 1'b0;
            fail_idx    <= '0;
            match_count <= '0;
            store_count <= '0;
        end else begin
            case (state)
                IDLE, PASS, FAIL: begin
                    if (start) begin
                        lenReg      <= clampedLen;
                        ptr         <= '0;
                        timer       <= '0;
                        fail        <= 1'b0;
                        timeout     <= 1'b0;
                        fail_idx    <= '0;
                        match_count <= '0;
                        store_count <= '0;
                        if (clampedLen == '0) begin
                            state <= PASS;
                            pass  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= RUN;
                            pass  <= 1'b0;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (TIMEOUT_CYCLES != 0) begin
                        timer <= timer + 32'd1;
                    end
                    if (MemWrite && store_count != 16'hFFFF) begin
                        store_count <= store_count + 16'd1;
                    end
                    if (storeHit) begin
                        ptr         <= ptr + 1'b1;
                        match_count <= match_count + 1'b1;
                    end
                    if (storeHit && lastEntry) begin
                        state <= PASS;
                        pass  <= 1'b1;
                        busy  <= 1'b0;
                    end else if (storeBad) begin
                        state    <= FAIL;
                        fail     <= 1'b1;
                        fail_idx <= ptr;
                        busy     <= 1'b0;
                    end else if (timerExpired) begin
                        state    <= FAIL;
                        fail     <= 1'b1;
                        timeout  <= 1'b1;
                        fail_idx <= ptr;
                        busy     <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_trace_checker.sv
// Directed bench: a strict and a loose checker share one stimulus stream and are
// checked against hand-computed verdicts.
module tb_store_trace_checker;

    logic        clk;
    logic        rst;
    logic        cfg_we;
    logic [1:0]  cfg_idx;
    logic [31:0] cfg_addr;
    logic [31:0] cfg_data;
    logic [2:0]  cfg_len;
    logic        start;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;

    logic        sBusy, sPass, sFail, sTimeout;
    logic [1:0]  sFailIdx;
    logic [2:0]  sMatch;
    logic [15:0] sStore;
    logic        lBusy, lPass, lFail, lTimeout;
    logic [1:0]  lFailIdx;
    logic [2:0]  lMatch;
    logic [15:0] lStore;

    int checks = 0;
    int errors = 0;

    store_trace_checker #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .TIMEOUT_CYCLES(16), .STRICT(1'b1)) dutStrict (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_len(cfg_len), .start(start), .MemWrite(MemWrite),
        .ALUResult(ALUResult), .WriteData(WriteData), .busy(sBusy), .pass(sPass),
        .fail(sFail), .timeout(sTimeout), .fail_idx(sFailIdx), .match_count(sMatch),
        .store_count(sStore)
    );

    store_trace_checker #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .TIMEOUT_CYCLES(16), .STRICT(1'b0)) dutLoose (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_len(cfg_len), .start(start), .MemWrite(MemWrite),
        .ALUResult(ALUResult), .WriteData(WriteData), .busy(lBusy), .pass(lPass),
        .fail(lFail), .timeout(lTimeout), .fail_idx(lFailIdx), .match_count(lMatch),
        .store_count(lStore)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // All helpers start and end on a falling edge, so each call spans whole cycles.
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] data);
        MemWrite  = we;
        ALUResult = addr;
        WriteData = data;
        @(negedge clk);
        MemWrite  = 1'b0;
    endtask

    task automatic writeEntry(input logic [1:0] idx, input logic [31:0] addr, input logic [31:0] data);
        cfg_we   = 1'b1;
        cfg_idx  = idx;
        cfg_addr = addr;
        cfg_data = data;
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic armChecker(input logic [2:0] len);
        cfg_len = len;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'd0, 32'd0);
    endtask

    task automatic resetPulse(input string tag);
        rst = 1'b0;
        #2;
        checkOutput({tag, ".sBusy"}, {31'd0, sBusy}, 32'd0);
        checkOutput({tag, ".sPass"}, {31'd0, sPass}, 32'd0);
        checkOutput({tag, ".sFail"}, {31'd0, sFail}, 32'd0);
        checkOutput({tag, ".sMatch"}, {29'd0, sMatch}, 32'd0);
        checkOutput({tag, ".sStore"}, {16'd0, sStore}, 32'd0);
        checkOutput({tag, ".lBusy"}, {31'd0, lBusy}, 32'd0);
        checkOutput({tag, ".lPass"}, {31'd0, lPass}, 32'd0);
        checkOutput({tag, ".lFail"}, {31'd0, lFail}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_addr = '0; cfg_data = '0;
        cfg_len = '0; start = 1'b0; MemWrite = 1'b0; ALUResult = '0; WriteData = '0;
        #3;
        checkOutput("reset.sTimeout", {31'd0, sTimeout}, 32'd0);
        checkOutput("reset.sFailIdx", {30'd0, sFailIdx}, 32'd0);
        checkOutput("reset.lStore", {16'd0, lStore}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Strict in-order pass with back-to-back stores
        writeEntry(2'd0, 32'd96, 32'd7);
        writeEntry(2'd1, 32'd100, 32'd25);
        armChecker(3'd2);
        checkOutput("t1.busyAfterStart", {31'd0, sBusy}, 32'd1);
        applyStimulus(1'b1, 32'd96, 32'd7);
        checkOutput("t1.notYetPass", {31'd0, sPass}, 32'd0);
        applyStimulus(1'b1, 32'd100, 32'd25);
        checkOutput("t1.pass", {31'd0, sPass}, 32'd1);
        checkOutput("t1.fail", {31'd0, sFail}, 32'd0);
        checkOutput("t1.busy", {31'd0, sBusy}, 32'd0);
        checkOutput("t1.match", {29'd0, sMatch}, 32'd2);
        checkOutput("t1.store", {16'd0, sStore}, 32'd2);
        applyStimulus(1'b1, 32'd8, 32'd8);
        checkOutput("t1.stickyPass", {31'd0, sPass}, 32'd1);
        checkOutput("t1.storeFrozen", {16'd0, sStore}, 32'd2);

        // Strict wrong address fails; loose ignores the same store
        armChecker(3'd2);
        applyStimulus(1'b1, 32'd104, 32'd7);
        checkOutput("t2.fail", {31'd0, sFail}, 32'd1);
        checkOutput("t2.pass", {31'd0, sPass}, 32'd0);
        checkOutput("t2.failIdx", {30'd0, sFailIdx}, 32'd0);
        checkOutput("t2.timeout", {31'd0, sTimeout}, 32'd0);
        checkOutput("t2.store", {16'd0, sStore}, 32'd1);
        checkOutput("t2.looseBusy", {31'd0, lBusy}, 32'd1);
        checkOutput("t2.looseStore", {16'd0, lStore}, 32'd1);

        // Loose mode skips unrelated stores
        resetPulse("t3.reset");
        writeEntry(2'd0, 32'd100, 32'd25);
        armChecker(3'd1);
        applyStimulus(1'b1, 32'd96, 32'd3);
        applyStimulus(1'b1, 32'd96, 32'd9);
        checkOutput("t3.looseStillBusy", {31'd0, lBusy}, 32'd1);
        applyStimulus(1'b1, 32'd100, 32'd25);
        checkOutput("t3.pass", {31'd0, lPass}, 32'd1);
        checkOutput("t3.store", {16'd0, lStore}, 32'd3);
        checkOutput("t3.match", {29'd0, lMatch}, 32'd1);
        checkOutput("t3.strictFail", {31'd0, sFail}, 32'd1);
        checkOutput("t3.strictStore", {16'd0, sStore}, 32'd1);

        // Loose mode: right address, wrong data
        armChecker(3'd1);
        applyStimulus(1'b1, 32'd100, 32'd24);
        checkOutput("t4.fail", {31'd0, lFail}, 32'd1);
        checkOutput("t4.pass", {31'd0, lPass}, 32'd0);
        checkOutput("t4.failIdx", {30'd0, lFailIdx}, 32'd0);
        checkOutput("t4.timeout", {31'd0, lTimeout}, 32'd0);

        // Watchdog fires exactly 16 cycles after the start edge
        armChecker(3'd1);
        idleCycles(15);
        checkOutput("t5.noFailAt15", {31'd0, sFail}, 32'd0);
        checkOutput("t5.busyAt15", {31'd0, sBusy}, 32'd1);
        idleCycles(1);
        checkOutput("t5.fail", {31'd0, sFail}, 32'd1);
        checkOutput("t5.timeout", {31'd0, sTimeout}, 32'd1);
        checkOutput("t5.looseTimeout", {31'd0, lTimeout}, 32'd1);
        checkOutput("t5.store", {16'd0, sStore}, 32'd0);

        // Final match on cycle 16 beats the watchdog
        armChecker(3'd1);
        idleCycles(15);
        applyStimulus(1'b1, 32'd100, 32'd25);
        checkOutput("t5b.pass", {31'd0, sPass}, 32'd1);
        checkOutput("t5b.fail", {31'd0, sFail}, 32'd0);
        checkOutput("t5b.timeout", {31'd0, sTimeout}, 32'd0);
        checkOutput("t5b.loosePass", {31'd0, lPass}, 32'd1);

        // Empty table passes immediately
        armChecker(3'd0);
        checkOutput("t6.emptyPass", {31'd0, sPass}, 32'd1);
        checkOutput("t6.emptyBusy", {31'd0, sBusy}, 32'd0);

        // Mid-run async reset, then cfg_we during RUN must be ignored
        armChecker(3'd1);
        idleCycles(2);
        resetPulse("t7.midRunReset");
        writeEntry(2'd0, 32'd100, 32'd25);
        armChecker(3'd1);
        writeEntry(2'd0, 32'd200, 32'd1);
        applyStimulus(1'b1, 32'd100, 32'd25);
        checkOutput("t7.passOrig", {31'd0, sPass}, 32'd1);
        armChecker(3'd1);
        applyStimulus(1'b1, 32'd100, 32'd25);
        checkOutput("t7.rerunPass", {31'd0, sPass}, 32'd1);
        checkOutput("t7.rerunMatch", {29'd0, sMatch}, 32'd1);

        // Same-cycle entry write and arm in IDLE uses the fresh entry
        resetPulse("t8.reset");
        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_addr = 32'd64; cfg_data = 32'd5;
        armChecker(3'd1);
        cfg_we = 1'b0;
        applyStimulus(1'b1, 32'd64, 32'd5);
        checkOutput("t8.pass", {31'd0, sPass}, 32'd1);
        checkOutput("t8.loosePass", {31'd0, lPass}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
